// File: rtl/persiana_pkg.sv
// +--------------------------------------------------------------------+
// | persiana_pkg: shared state encodings and widths for the blind motor |
// | driver. Revision: 1.0                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package persiana_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_RUN   = 3'd2,
        S_BRAKE = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam int PWM_W  = 8;
    localparam int WDOG_W = 16;

    // Duty increment saturating at lim; the sum is one bit wider so it never wraps.
    function automatic logic [PWM_W-1:0] sat_add(input logic [PWM_W-1:0] a,
                                                 input logic [PWM_W-1:0] b,
                                                 input logic [PWM_W-1:0] lim);
        logic [PWM_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= {1'b0, lim}) ? lim : sum[PWM_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/persiana_pwm_gen.sv
// +--------------------------------------------------------------------+
// | persiana_pwm_gen: free-running counter, duty compare, registered   |
// | PWM output. Revision: 1.0                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module persiana_pwm_gen
    import persiana_pkg::*;
#(
    parameter int W = PWM_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] duty,
    output logic         pwm
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         pwm_q, pwm_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        pwm_d = en && (cnt_q < duty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

`default_nettype wire

// File: rtl/persiana_motor_driver.sv
// +--------------------------------------------------------------------+
// | persiana_motor_driver: H-bridge driver with soft-start, brake dead |
// | time, conflict guard and watchdog. Soft-start: PERSIANA_SOFTSTART_EN|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module persiana_motor_driver
    import persiana_pkg::*;
#(
    parameter int DUTY_MAX      = 255,
    parameter int RAMP_STEP     = 32,
    parameter int DEAD_TICKS    = 4,
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       tick_i,
    input  logic       subir_i,
    input  logic       bajar_i,
    output logic       pwm_o,
    output logic       dir_o,
    output logic       en_o,
    output logic       busy_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    localparam logic [PWM_W-1:0]  DUTY_MAX_C = PWM_W'(DUTY_MAX);
    localparam logic [7:0]        DEAD_C     = 8'(DEAD_TICKS);
    localparam logic [WDOG_W-1:0] TIMEOUT_C  = WDOG_W'(TIMEOUT_TICKS);

    if (DUTY_MAX < 1 || DUTY_MAX > 255 || RAMP_STEP < 1 || RAMP_STEP > 255 ||
        DEAD_TICKS < 1 || DEAD_TICKS > 255 || TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 65535)
    begin : g_param_range_error
        $error("persiana_motor_driver: parameter out of range");
    end

    state_t              state_q, state_d;
    logic [PWM_W-1:0]    duty_q, duty_d;
    logic [7:0]          dead_q, dead_d;
    logic [WDOG_W-1:0]   run_q, run_d;
    logic                dir_q, dir_d;

    logic req_up, req_dn, req_keep, wdog_hit, en_d;

    assign req_up   = ena && subir_i && !bajar_i;
    assign req_dn   = ena && bajar_i && !subir_i;
    assign req_keep = dir_q ? req_up : req_dn;
    assign wdog_hit = tick_i && ((run_q + WDOG_W'(1)) == TIMEOUT_C);

`ifdef PERSIANA_SOFTSTART_EN
    localparam logic [PWM_W-1:0] STEP_C = PWM_W'(RAMP_STEP);
    logic [PWM_W-1:0] ramp_next;
    assign ramp_next = sat_add(duty_q, STEP_C, DUTY_MAX_C);
`endif

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dead_d  = dead_q;
        run_d   = run_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                duty_d = '0;
                if (req_up || req_dn) begin
                    dir_d = req_up;
                    run_d = '0;
`ifdef PERSIANA_SOFTSTART_EN
                    state_d = S_RAMP;
`else
                    state_d = S_RUN;
                    duty_d  = DUTY_MAX_C;
`endif
                end
            end
            S_RAMP, S_RUN: begin
                // Watchdog outranks the brake; both outrank the ramp step.
                if (wdog_hit) begin
                    state_d = S_FAULT;
                    duty_d  = '0;
                end else if (!req_keep) begin
                    state_d = S_BRAKE;
                    duty_d  = '0;
                    dead_d  = DEAD_C;
                end else if (tick_i) begin
                    run_d = run_q + WDOG_W'(1);
`ifdef PERSIANA_SOFTSTART_EN
                    if (state_q == S_RAMP) begin
                        duty_d = ramp_next;
                        if (ramp_next == DUTY_MAX_C) state_d = S_RUN;
                    end
`endif
                end
            end
            S_BRAKE: begin
                duty_d = '0;
                if (tick_i) begin
                    if (dead_q <= 8'd1) begin
                        dead_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        dead_d = dead_q - 8'd1;
                    end
                end
            end
            S_FAULT: begin
                duty_d = '0;
                if (tick_i && !subir_i && !bajar_i) state_d = S_IDLE;
            end
            default: begin
                state_d = S_FAULT;
                duty_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            dead_q  <= '0;
            run_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
            run_q   <= run_d;
            dir_q   <= dir_d;
        end
    end

    // The PWM register looks at next-cycle enable/duty so it lines up with the state it serves.
    assign en_d = (state_d == S_RAMP) || (state_d == S_RUN);

    persiana_pwm_gen #(
        .W (PWM_W)
    ) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_d),
        .duty  (duty_d),
        .pwm   (pwm_o)
    );

    assign en_o    = (state_q == S_RAMP) || (state_q == S_RUN);
    assign busy_o  = (state_q != S_IDLE);
    assign fault_o = (state_q == S_FAULT);
    assign dir_o   = dir_q;
    assign state_o = state_q;

endmodule

`default_nettype wire
